// File: rtl/mul_share_ctrl.sv
// Two-requester round-robin front end for a shared WIDTHxWIDTH shift-add multiplier.
// Each accepted operand pair takes exactly WIDTH iterations; the product is returned tagged with its owner.
module mul_share_ctrl #(
    parameter int WIDTH = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic [2*WIDTH-1:0] res,
    output logic               res_id,
    output logic               res_valid,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam logic [3:0] LAST_ITER = 4'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             pend_id_q, pend_id_d;
    logic             last_grant_q, last_grant_d;
    logic [PW-1:0]    res_q, res_d;
    logic             res_id_q, res_id_d;
    logic             res_valid_q, res_valid_d;

    logic             grant0, grant1, accept;
    logic [PW-1:0]    sum;

    // On contention the requester that did not win last time is granted.
    assign grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    assign accept = req0_ready | req1_ready;
    assign sum    = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: state is written with <= so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt_q == LAST_ITER) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // Readys are gated by reset_n so nothing is offered while reset is held.
        req0_ready = reset_n & (state_q == IDLE) & grant0;
        req1_ready = reset_n & (state_q == IDLE) & grant1;
        busy       = (state_q == RUN);
    end

    always_comb begin
        mplier_d     = mplier_q;
        mcand_d      = mcand_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        pend_id_d    = pend_id_q;
        last_grant_d = last_grant_q;
        res_d        = res_q;
        res_id_d     = res_id_q;
        res_valid_d  = 1'b0;
        if (state_q == IDLE && accept) begin
            mplier_d     = req1_ready ? req1_a : req0_a;
            mcand_d      = {{WIDTH{1'b0}}, (req1_ready ? req1_b : req0_b)};
            acc_d        = '0;
            cnt_d        = '0;
            pend_id_d    = req1_ready;
            last_grant_d = req1_ready;
        end else if (state_q == RUN) begin
            acc_d    = sum;
            mplier_d = mplier_q >> 1;
            mcand_d  = mcand_q << 1;
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == LAST_ITER) begin
                res_d       = sum;
                res_id_d    = pend_id_q;
                res_valid_d = 1'b1;
            end
        end
    end

    // NOTE: the small datapath registers are all reset so an aborted run leaves no stale state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mplier_q     <= '0;
            mcand_q      <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            pend_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
            res_q        <= '0;
            res_id_q     <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            mplier_q     <= mplier_d;
            mcand_q      <= mcand_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            pend_id_q    <= pend_id_d;
            last_grant_q <= last_grant_d;
            res_q        <= res_d;
            res_id_q     <= res_id_d;
            res_valid_q  <= res_valid_d;
        end
    end

    assign res       = res_q;
    assign res_id    = res_id_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: cycle-level arithmetic model plus directed scenarios with literal results.
module tb_mul_share_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [8:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic [17:0] res;
    logic        res_id, res_valid, busy;

    int checks = 0;
    int failures = 0;

    mul_share_ctrl #(.WIDTH(9)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res(res), .res_id(res_id), .res_valid(res_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: remaining busy cycles, round-robin pointer, one in-flight product due at a cycle index.
    int m_left, m_last, m_due, m_cyc, m_prod, m_pid, m_res, m_id;
    logic e_busy, e_r0, e_r1, e_rv;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_left = 0; m_last = 1; m_due = -1; m_res = 0; m_id = 0;
            check("rst_busy", 32'(busy), 0);
            check("rst_ready0", 32'(req0_ready), 0);
            check("rst_ready1", 32'(req1_ready), 0);
            check("rst_res_valid", 32'(res_valid), 0);
            check("rst_res", 32'(res), 0);
            check("rst_res_id", 32'(res_id), 0);
        end else begin
            e_busy = (m_left > 0);
            e_r0 = !e_busy && req0_valid && (!req1_valid || m_last == 1);
            e_r1 = !e_busy && req1_valid && (!req0_valid || m_last == 0);
            e_rv = (m_due == m_cyc);
            if (e_rv) begin
                m_res = m_prod; m_id = m_pid; m_due = -1;
            end
            check("busy", 32'(busy), 32'(e_busy));
            check("ready0", 32'(req0_ready), 32'(e_r0));
            check("ready1", 32'(req1_ready), 32'(e_r1));
            check("res_valid", 32'(res_valid), 32'(e_rv));
            check("res", 32'(res), 32'(m_res));
            check("res_id", 32'(res_id), 32'(m_id));
            if (e_r0) begin
                m_last = 0; m_left = 9; m_due = m_cyc + 10; m_pid = 0;
                m_prod = int'(req0_a) * int'(req0_b);
            end else if (e_r1) begin
                m_last = 1; m_left = 9; m_due = m_cyc + 10; m_pid = 1;
                m_prod = int'(req1_a) * int'(req1_b);
            end else if (m_left > 0) begin
                m_left--;
            end
        end
        m_cyc++;
    end

    // Present an operand pair, wait for its grant, then drop valid right after the accept edge.
    task automatic issue(input int id, input int a, input int b);
        int n;
        @(posedge clk); #1;
        if (id == 0) begin req0_valid = 1; req0_a = 9'(a); req0_b = 9'(b); end
        else         begin req1_valid = 1; req1_a = 9'(a); req1_b = 9'(b); end
        n = 0;
        forever begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) break;
            n++;
            if (n > 30) begin
                check("grant_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk); #1;
        if (id == 0) req0_valid = 0; else req1_valid = 0;
    endtask

    // Wait for res_valid; lat>0 also checks the negedge count since the accept edge.
    task automatic wait_res(input string name, input int exp_res, input int exp_id, input int lat);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (res_valid) break;
            if (n > 40) begin
                check({name, "_timeout"}, 1, 0);
                return;
            end
        end
        check({name, "_res"}, 32'(res), 32'(exp_res));
        check({name, "_id"}, 32'(res_id), 32'(exp_id));
        if (lat > 0) check({name, "_latency"}, 32'(n), 32'(lat));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        reset_n = 0;
        @(negedge clk);
        @(posedge clk); #2;
        reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int ids [6];
        reset_n = 0;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        repeat (2) @(negedge clk);

        // Both valid during reset: nothing offered; req0 wins first after release.
        req0_a = 3; req0_b = 5; req0_valid = 1;
        req1_a = 7; req1_b = 9; req1_valid = 1;
        @(negedge clk);
        check("lit_rst_ready0", 32'(req0_ready), 0);
        check("lit_rst_ready1", 32'(req1_ready), 0);
        @(posedge clk); #2;
        reset_n = 1;
        wait_res("simul0", 15, 0, 0);
        check("simul_ready1_after", 32'(req1_ready), 1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        wait_res("simul1", 63, 1, 10);

        // Single request with operands scrambled after accept.
        issue(0, 13, 11);
        req0_a = 9'd500; req0_b = 9'd77;
        wait_res("single", 143, 0, 10);

        issue(0, 511, 511); wait_res("max", 261121, 0, 10);
        issue(1, 0, 300);   wait_res("zero", 0, 1, 10);
        issue(0, 1, 511);   wait_res("one_x", 511, 0, 10);
        issue(1, 511, 1);   wait_res("x_one", 511, 1, 10);

        // req1 valid while busy must not be granted until IDLE.
        issue(0, 21, 3);
        req1_valid = 1; req1_a = 6; req1_b = 7;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (req1_ready) n++;
        end
        check("busy_ignore_cnt", 32'(n), 0);
        @(negedge clk);
        check("busy_ignore_res", 32'(res), 63);
        check("busy_ignore_ready1", 32'(req1_ready), 1);
        @(posedge clk); #1;
        req1_valid = 0;
        wait_res("after_busy", 42, 1, 10);

        // Fairness from a fresh reset: ids alternate starting with 0.
        pulse_reset();
        req0_a = 10; req0_b = 20; req0_valid = 1;
        req1_a = 30; req1_b = 3;  req1_valid = 1;
        for (int i = 0; i < 6; i++) begin
            wait_res("fair", (i % 2 == 0) ? 200 : 90, i % 2, 0);
            ids[i] = int'(res_id);
        end
        check("fair_seq", 32'({ids[0][0], ids[1][0], ids[2][0], ids[3][0], ids[4][0], ids[5][0]}), 32'b010101);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        check("fair_drain", 32'(busy), 0);

        // Reset after the 5th iteration of 200*100: outputs clear at once, no result appears.
        issue(0, 200, 100);
        repeat (5) @(posedge clk);
        #2 reset_n = 0;
        #1;
        check("mid_rst_res", 32'(res), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_res_valid", 32'(res_valid), 0);
        @(negedge clk);
        @(posedge clk); #2;
        reset_n = 1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid) n++;
        end
        check("mid_rst_no_result", 32'(n), 0);
        issue(1, 12, 12);
        wait_res("post_rst", 144, 1, 10);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_share_ctrl.md
# mul_share_ctrl

Two-requester arbiter and sequencer for a shared 9x9 unsigned shift-add multiplier engine. Two independent clients submit operand pairs over valid/ready handshakes. The block grants one request at a time using round-robin, runs the 9-iteration shift-add sequence internally, and returns the 18-bit product tagged with the winning requester's id. It sits between the lab's operand sources (switch/register front ends) and the result display/consumer logic.

## Interface
- WIDTH, 9, operand width; product width is 2*WIDTH. Only 9 is verified.
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_a  in  WIDTH  requester 0 multiplier operand
- req0_b  in  WIDTH  requester 0 multiplicand operand
- req0_ready  out  1  requester 0 accepted this cycle (combinational)
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0
- res  out  2*WIDTH  last completed product (registered, held)
- res_id  out  1  requester that owns res (registered, held)
- res_valid  out  1  one-cycle pulse, res/res_id are new
- busy  out  1  high while a multiplication is in progress

## Operation
- States: IDLE, RUN.
- IDLE:
  - Grant logic is combinational from the valids and the last_grant pointer.
  - Only one valid high: that requester wins.
  - Both valid high: the requester other than last_grant wins.
  - reqN_ready = (state==IDLE) & grantN. At most one ready is high in any cycle.
- Accept edge (valid & ready):
  - Latch a into the multiplier register.
  - Latch b, zero-extended to 2*WIDTH, into the multiplicand register.
  - Clear the accumulator. Clear the 4-bit counter.
  - Store id into a pending-id register. Set last_grant = id.
  - Go to RUN.
- RUN, each edge:
  - If multiplier[0], accumulator += multiplicand.
  - Multiplier >>= 1; multiplicand <<= 1; counter += 1.
- RUN, on the edge where counter==WIDTH-1 (9th iteration):
  - res <= final sum, including this iteration's add.
  - res_id <= pending id; res_valid <= 1.
  - State <= IDLE.
- res_valid returns to 0 on the next edge.
- Arithmetic is unsigned with no overflow possible: 511*511 = 261121 < 2^18. The product does not depend on which operand is the multiplier.
- Operands are sampled only at the accept edge. Changes to reqN_a/b afterwards have no effect on the running product.
- A requester may drop valid before it is granted; nothing is captured. Valid asserted while busy is ignored (ready=0) until the block returns to IDLE.
- No early termination: every operation takes exactly 9 iterations, including zero operands.
- busy = (state==RUN).

## Timing
- reset_n low (asynchronous, any time, including mid-RUN):
  - State=IDLE, res=0, res_id=0, res_valid=0, busy=0, counter=0, accumulator=0.
  - last_grant=1, so requester 0 wins the first simultaneous request.
  - Both readys are 0 while reset_n is low.
  - An interrupted operation produces no res_valid and is lost.
- Accept at edge T0:
  - busy is high from T0 to T9.
  - Iterations run on edges T1..T9.
  - res_valid is high for the single cycle between T9 and T10, with res/res_id valid from T9.
- The first cycle after T9 is IDLE, so readys may be high there and the next accept can occur at T10. Throughput is one product per 10 cycles.
- res_valid and a new accept may coincide in the same cycle.
- Two requesters continuously valid alternate 0,1,0,1,...

## Test plan
- Single request: req0 a=13, b=11 accepted at T0 -> res=143, res_id=0, res_valid high one cycle after T9; busy high T0–T9.
- Simultaneous first requests after reset: req0 (3,5), req1 (7,9) both held valid -> req0 granted first (res=15, id=0), req1_ready high in the following IDLE cycle, then res=63, id=1.
- Extremes: (511,511) -> 261121; (0,300) -> 0, still 9 iterations; (1,511) -> 511; (511,1) -> 511.
- Fairness: both valid continuously for 6 operations -> res_id sequence 0,1,0,1,0,1 with no starvation; readys never both high.
- Reset mid-operation: reset_n low after the 5th iteration of (200,100) -> all outputs 0 immediately and no res_valid. After release, req1 (12,12) -> 144, id=1.
- Operand stability and ignore-while-busy: change req0_a/b after accept -> product uses the accept-edge values. req1_valid during RUN -> req1_ready stays 0 until IDLE.
